// File: rtl/sdm_pkg.sv
// Shared types and constants for the sigma-delta sample sequencer.
package sdm_pkg;

   localparam int MOD_VALUE_W = 32;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_PRIME,
      SEQ_RUN
   } seq_state_t;

endpackage

// File: rtl/sdm_sync_fifo.sv
// Single-clock show-ahead FIFO buffering stream samples for the sequencer.
// Pointers carry one extra MSB so that full and empty can be told apart.
module sdm_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [DATA_W-1:0]      wdata_i,
   output logic [DATA_W-1:0]      rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wrPtr_q;
   logic [AW:0]       rdPtr_q;
   logic              doPush;
   logic              doPop;

   // Status flags, head-of-queue data, and the qualified push/pop strobes.
   // A push into a full FIFO is allowed when a pop frees the slot in the same cycle.
   always_comb begin
      empty_o = (wrPtr_q == rdPtr_q);
      full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
      level_o = wrPtr_q - rdPtr_q;
      rdata_o = mem_q[rdPtr_q[AW-1:0]];
      doPop   = pop_i && !empty_o;
      doPush  = push_i && (!full_o || doPop);
   end

   // Sample storage; no reset needed since occupancy is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (doPush && !flush_i) begin
         mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
      end
   end

   // Pointer update; flush discards everything including a same-cycle push.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else if (flush_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdm_sample_sequencer.sv
// Buffers AXI-Stream samples and issues one per programmed period to the
// sigma-delta modulator, flagging underruns when the buffer runs dry.
module sdm_sample_sequencer
   import sdm_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int DIV_W  = 16
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   enable,
   input  logic [DIV_W-1:0]       div,
   input  logic [DATA_W-1:0]      s_tdata,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   output logic                   mod_enable,
   output logic [MOD_VALUE_W-1:0] mod_value,
   output logic [$clog2(DEPTH):0] level,
   output logic                   underrun
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] PRIME_LEVEL = LW'(DEPTH / 2);

   seq_state_t             state_q;
   logic [DIV_W-1:0]       tickCnt_q;
   logic [DIV_W-1:0]       tickCnt_d;
   logic [DIV_W-1:0]       divLatched_q;
   logic [MOD_VALUE_W-1:0] modValue_q;
   logic                   modEnable_q;
   logic                   underrun_q;

   logic                   fifoPush;
   logic                   fifoPop;
   logic                   fifoFlush;
   logic                   fifoFull;
   logic                   fifoEmpty;
   logic [DATA_W-1:0]      fifoData;
   logic [LW-1:0]          fifoLevel;
   logic                   primeDone;
   logic                   tickNow;

   // Pop requests come from the prime-to-run handover and from each period tick.
   // Ready also opens when a full FIFO is popped, so push and pop can overlap at full.
   // Ready is gated by enable so a beat offered during the disabling cycle is not taken.
   always_comb begin
      primeDone = (state_q == SEQ_PRIME) && enable && (fifoLevel >= PRIME_LEVEL);
      tickNow   = (state_q == SEQ_RUN) && enable && (tickCnt_q == divLatched_q);
      tickCnt_d = tickNow ? '0 : tickCnt_q + 1'b1;
      fifoPop   = (primeDone || tickNow) && !fifoEmpty;
      fifoFlush = (state_q == SEQ_IDLE) || !enable;
      s_tready  = (state_q != SEQ_IDLE) && enable && (!fifoFull || fifoPop);
      fifoPush  = s_tvalid && s_tready;
   end

   sdm_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) uFifo (
      .clk_i   (aclk),
      .rst_ni  (aresetn),
      .push_i  (fifoPush),
      .pop_i   (fifoPop),
      .flush_i (fifoFlush),
      .wdata_i (s_tdata),
      .rdata_o (fifoData),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .level_o (fifoLevel)
   );

   // Sequencer FSM with tick counter and registered modulator outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= SEQ_IDLE;
         tickCnt_q    <= '0;
         divLatched_q <= '0;
         modValue_q   <= '0;
         modEnable_q  <= 1'b0;
         underrun_q   <= 1'b0;
      end else if (!enable) begin
         state_q      <= SEQ_IDLE;
         tickCnt_q    <= '0;
         divLatched_q <= '0;
         modValue_q   <= '0;
         modEnable_q  <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         case (state_q)
            SEQ_IDLE: begin
               state_q <= SEQ_PRIME;
            end
            SEQ_PRIME: begin
               if (primeDone) begin
                  state_q      <= SEQ_RUN;
                  tickCnt_q    <= '0;
                  divLatched_q <= div;
                  modValue_q   <= MOD_VALUE_W'(fifoData);
                  modEnable_q  <= 1'b1;
               end
            end
            SEQ_RUN: begin
               tickCnt_q <= tickCnt_d;
               if (tickNow) begin
                  divLatched_q <= div;
                  if (fifoEmpty) begin
                     underrun_q <= 1'b1;
                  end else begin
                     modValue_q  <= MOD_VALUE_W'(fifoData);
                     modEnable_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= SEQ_IDLE;
            end
         endcase
      end
   end

   assign mod_enable = modEnable_q;
   assign mod_value  = modValue_q;
   assign underrun   = underrun_q;
   assign level      = fifoLevel;

endmodule

// File: tb/tb_sdm_sample_sequencer.sv
// Self-checking bench for sdm_sample_sequencer: accepted stream beats are
// queued as expected modulator values and popped when a sample is due.
module tb_sdm_sample_sequencer;

   logic        aclk;
   logic        aresetn;
   logic        enable;
   logic [15:0] div;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic        mod_enable;
   logic [31:0] mod_value;
   logic [4:0]  level;
   logic        underrun;

   int          checks;
   int          errors;
   int          acceptCnt;
   logic [7:0]  expQ[$];
   bit          srcOn;
   logic [7:0]  srcLast;

   sdm_sample_sequencer #(
      .DATA_W (8),
      .DEPTH  (16),
      .DIV_W  (16)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .enable     (enable),
      .div        (div),
      .s_tdata    (s_tdata),
      .s_tvalid   (s_tvalid),
      .s_tready   (s_tready),
      .mod_enable (mod_enable),
      .mod_value  (mod_value),
      .level      (level),
      .underrun   (underrun)
   );

   // Free-running 100 MHz clock.
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Hard stop in case a test never returns.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One clock: record the handshake due at the coming edge, then advance the source.
   task automatic cycle();
      bit acc;
      #1;
      acc = aresetn && s_tvalid && s_tready;
      if (!aresetn || !enable) begin
         expQ.delete();
      end else if (acc) begin
         expQ.push_back(s_tdata);
         acceptCnt++;
      end
      @(negedge aclk);
      if (srcOn && acc) begin
         if (s_tdata == srcLast) begin
            s_tvalid = 1'b0;
            srcOn    = 1'b0;
         end else begin
            s_tdata = s_tdata + 8'd1;
         end
      end
   endtask

   task automatic startStream(input logic [7:0] first, input logic [7:0] last);
      s_tdata  = first;
      s_tvalid = 1'b1;
      srcLast  = last;
      srcOn    = 1'b1;
   endtask

   task automatic popExp(output logic [31:0] v);
      if (expQ.size() == 0) begin
         v = 32'hxxxxxxxx;
      end else begin
         v = {24'h0, expQ.pop_front()};
      end
   endtask

   task automatic waitRise(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (mod_enable === 1'b1) begin
            ok = 1'b1;
            break;
         end
         cycle();
      end
   endtask

   task automatic stopAll();
      enable   = 1'b0;
      s_tvalid = 1'b0;
      srcOn    = 1'b0;
      cycle();
      cycle();
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         enable   = 1'($urandom);
         div      = 16'($urandom);
         s_tdata  = 8'($urandom);
         s_tvalid = 1'($urandom);
         cycle();
         checks++;
         if (mod_enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mod_enable: got %b expected 0", mod_enable);
         end
         checks++;
         if (mod_value !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mod_value: got %h expected 0", mod_value);
         end
         checks++;
         if (s_tready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_s_tready: got %b expected 0", s_tready);
         end
         checks++;
         if (underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_underrun: got %b expected 0", underrun);
         end
         checks++;
         if (level !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_level: got %0d expected 0", level);
         end
      end
      enable   = 1'b0;
      s_tvalid = 1'b0;
      aresetn  = 1'b1;
      cycle();
   endtask

   task automatic test_stream();
      bit          ok;
      logic [4:0]  prevLevel;
      logic [31:0] exp;
      logic [31:0] last;
      div    = 16'd3;
      enable = 1'b1;
      startStream(8'h10, 8'h1F);
      ok        = 1'b0;
      prevLevel = '0;
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (mod_enable === 1'b1) begin
            ok = 1'b1;
            break;
         end
         prevLevel = level;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL stream_rise_timeout: mod_enable=%b expected 1 within 60 cycles", mod_enable);
      end
      checks++;
      if (prevLevel !== 5'd8) begin
         errors++;
         $display("[TB] FAIL stream_prime_level: level before run %0d expected 8", prevLevel);
      end
      popExp(exp);
      checks++;
      if (mod_value !== exp) begin
         errors++;
         $display("[TB] FAIL stream_first: got %h expected %h", mod_value, exp);
      end
      last = exp;
      for (int k = 1; k < 8; k++) begin
         repeat (3) cycle();
         checks++;
         if (mod_value !== last) begin
            errors++;
            $display("[TB] FAIL stream_hold_%0d: got %h expected %h", k, mod_value, last);
         end
         cycle();
         popExp(exp);
         checks++;
         if (mod_value !== exp) begin
            errors++;
            $display("[TB] FAIL stream_step_%0d: got %h expected %h", k, mod_value, exp);
         end
         last = exp;
      end
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stream_underrun: got %b expected 0", underrun);
      end
      stopAll();
   endtask

   task automatic test_underrun();
      bit          ok;
      logic [31:0] exp;
      logic [31:0] last;
      div    = 16'd1;
      enable = 1'b1;
      startStream(8'h30, 8'h37);
      waitRise(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL underrun_rise_timeout: mod_enable=%b expected 1", mod_enable);
      end
      popExp(exp);
      last = exp;
      for (int k = 1; k < 8; k++) begin
         cycle();
         cycle();
         popExp(exp);
         checks++;
         if (mod_value !== exp) begin
            errors++;
            $display("[TB] FAIL underrun_step_%0d: got %h expected %h", k, mod_value, exp);
         end
         last = exp;
      end
      cycle();
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL underrun_early: got %b expected 0", underrun);
      end
      cycle();
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL underrun_set: got %b expected 1", underrun);
      end
      checks++;
      if (mod_value !== 32'h37) begin
         errors++;
         $display("[TB] FAIL underrun_hold_value: got %h expected %h", mod_value, 32'h37);
      end
      repeat (10) cycle();
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL underrun_sticky: got %b expected 1", underrun);
      end
      checks++;
      if (mod_enable !== 1'b1 || s_tready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL underrun_still_run: mod_enable=%b s_tready=%b expected 1 1", mod_enable, s_tready);
      end
      checks++;
      if (mod_value !== last) begin
         errors++;
         $display("[TB] FAIL underrun_value_kept: got %h expected %h", mod_value, last);
      end
      enable = 1'b0;
      cycle();
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL underrun_clear: got %b expected 0", underrun);
      end
      stopAll();
   endtask

   task automatic test_full();
      bit          ok;
      int          startAcc;
      int          elapsed;
      logic [31:0] exp;
      startAcc = acceptCnt;
      div      = 16'd1000;
      enable   = 1'b1;
      startStream(8'h40, 8'h53);
      waitRise(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL full_rise_timeout: mod_enable=%b expected 1", mod_enable);
      end
      popExp(exp);
      checks++;
      if (mod_value !== exp) begin
         errors++;
         $display("[TB] FAIL full_first: got %h expected %h", mod_value, exp);
      end
      repeat (30) cycle();
      elapsed = 30;
      checks++;
      if (level !== 5'd16 || s_tready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL full_level: level=%0d s_tready=%b expected 16 0", level, s_tready);
      end
      checks++;
      if (acceptCnt - startAcc !== 17) begin
         errors++;
         $display("[TB] FAIL full_accepted: got %0d expected 17", acceptCnt - startAcc);
      end
      ok = 1'b0;
      for (int i = 0; i < 1100; i++) begin
         cycle();
         elapsed++;
         if (mod_value !== 32'h40) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || elapsed != 1001) begin
         errors++;
         $display("[TB] FAIL full_tick_time: tick after %0d cycles expected 1001", elapsed);
      end
      popExp(exp);
      checks++;
      if (mod_value !== exp) begin
         errors++;
         $display("[TB] FAIL full_tick_value: got %h expected %h", mod_value, exp);
      end
      checks++;
      if (level !== 5'd16) begin
         errors++;
         $display("[TB] FAIL full_push_pop_level: got %0d expected 16", level);
      end
      checks++;
      if (acceptCnt - startAcc !== 18) begin
         errors++;
         $display("[TB] FAIL full_push_at_tick: accepted %0d expected 18", acceptCnt - startAcc);
      end
      stopAll();
   endtask

   task automatic test_div_change();
      bit          ok;
      logic [31:0] exp;
      logic [31:0] last;
      div    = 16'd3;
      enable = 1'b1;
      startStream(8'h60, 8'h6F);
      waitRise(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL divchg_rise_timeout: mod_enable=%b expected 1", mod_enable);
      end
      popExp(last);
      cycle();
      cycle();
      div = 16'd7;
      cycle();
      checks++;
      if (mod_value !== last) begin
         errors++;
         $display("[TB] FAIL divchg_cur_hold: got %h expected %h", mod_value, last);
      end
      cycle();
      popExp(exp);
      checks++;
      if (mod_value !== exp) begin
         errors++;
         $display("[TB] FAIL divchg_cur_tick: got %h expected %h", mod_value, exp);
      end
      last = exp;
      for (int k = 0; k < 2; k++) begin
         repeat (7) cycle();
         checks++;
         if (mod_value !== last) begin
            errors++;
            $display("[TB] FAIL divchg_new_hold_%0d: got %h expected %h", k, mod_value, last);
         end
         cycle();
         popExp(exp);
         checks++;
         if (mod_value !== exp) begin
            errors++;
            $display("[TB] FAIL divchg_new_tick_%0d: got %h expected %h", k, mod_value, exp);
         end
         last = exp;
      end
      stopAll();
   endtask

   task automatic test_disable();
      bit ok;
      int acc0;
      div    = 16'd1;
      enable = 1'b1;
      startStream(8'h70, 8'h77);
      waitRise(ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (level === 5'd5) begin
            ok = 1'b1;
            break;
         end
         cycle();
      end
      checks++;
      if (!ok || mod_enable !== 1'b1) begin
         errors++;
         $display("[TB] FAIL disable_setup: level=%0d mod_enable=%b expected 5 1", level, mod_enable);
      end
      enable   = 1'b0;
      srcOn    = 1'b0;
      s_tdata  = 8'hAA;
      s_tvalid = 1'b1;
      acc0     = acceptCnt;
      cycle();
      checks++;
      if (level !== 5'd0 || mod_value !== 32'h0) begin
         errors++;
         $display("[TB] FAIL disable_flush: level=%0d mod_value=%h expected 0 0", level, mod_value);
      end
      checks++;
      if (mod_enable !== 1'b0 || underrun !== 1'b0 || s_tready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL disable_outputs: mod_enable=%b underrun=%b s_tready=%b expected 0 0 0", mod_enable, underrun, s_tready);
      end
      checks++;
      if (acceptCnt !== acc0) begin
         errors++;
         $display("[TB] FAIL disable_beat_kept: accepted %0d expected %0d", acceptCnt, acc0);
      end
      enable = 1'b1;
      cycle();
      checks++;
      if (s_tready !== 1'b1 || mod_enable !== 1'b0 || level !== 5'd0) begin
         errors++;
         $display("[TB] FAIL reenable_prime: s_tready=%b mod_enable=%b level=%0d expected 1 0 0", s_tready, mod_enable, level);
      end
      cycle();
      checks++;
      if (level !== 5'd1 || mod_enable !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reenable_accept: level=%0d mod_enable=%b expected 1 0", level, mod_enable);
      end
      stopAll();
   endtask

   task automatic test_async_reset();
      bit ok;
      div    = 16'd1;
      enable = 1'b1;
      startStream(8'h80, 8'h87);
      waitRise(ok);
      #2;
      aresetn = 1'b0;
      #1;
      checks++;
      if (mod_enable !== 1'b0 || mod_value !== 32'h0) begin
         errors++;
         $display("[TB] FAIL async_reset_outputs: mod_enable=%b mod_value=%h expected 0 0", mod_enable, mod_value);
      end
      checks++;
      if (level !== 5'd0 || s_tready !== 1'b0 || underrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset_state: level=%0d s_tready=%b underrun=%b expected 0 0 0", level, s_tready, underrun);
      end
      enable   = 1'b0;
      s_tvalid = 1'b0;
      srcOn    = 1'b0;
      cycle();
      aresetn = 1'b1;
      cycle();
   endtask

   // Test sequence.
   initial begin
      checks    = 0;
      errors    = 0;
      acceptCnt = 0;
      srcOn     = 1'b0;
      srcLast   = 8'h0;
      aresetn   = 1'b0;
      enable    = 1'b0;
      div       = 16'd0;
      s_tdata   = 8'h0;
      s_tvalid  = 1'b0;
      @(negedge aclk);
      test_reset();
      test_stream();
      test_underrun();
      test_full();
      test_div_change();
      test_disable();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
